// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - program ROM arbiter between MCU fetch port and host download port
// Optional download checksum is built only when ROM_CHECKSUM_EN is defined.
module rom_arbiter #(
  parameter int AW          = 11,
  parameter int RELEASE_CYC = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cpu_req,
  input  logic [AW-1:0] i_cpu_addr,
  output logic [7:0]    o_cpu_data,
  output logic          o_cpu_valid,
  output logic          o_cpu_rst,
  input  logic          i_dl_busy,
  input  logic          i_dl_wr,
  input  logic [AW-1:0] i_dl_addr,
  input  logic [7:0]    i_dl_data,
  output logic          o_dl_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [7:0]    o_mem_wdata,
  input  logic [7:0]    i_mem_rdata,
  output logic [7:0]    o_checksum
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(RELEASE_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_cpu_valid;
  logic       r_dl_ack;
  logic       w_wr_accept;
  logic       w_rd_accept;
  logic       w_load_entry;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_HOLD;
      r_cnt   <= CNT_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // HOLD counts RELEASE_CYC-1 down to 0, so the CPU sees exactly RELEASE_CYC held cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (i_dl_busy) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!i_dl_busy) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      ST_HOLD: begin
        if (i_dl_busy) begin
          w_state_nxt = ST_LOAD;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = CNT_INIT;
      end
    endcase
  end

  // A read issued in the cycle dl_busy rises loses the ROM, so it never returns data.
  assign w_wr_accept  = (r_state == ST_LOAD) && i_dl_wr && !i_reset;
  assign w_rd_accept  = (r_state == ST_RUN) && i_cpu_req && !i_dl_busy && !i_reset;
  assign w_load_entry = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpu_valid <= 1'b0;
      r_dl_ack    <= 1'b0;
    end else begin
      r_cpu_valid <= w_rd_accept;
      r_dl_ack    <= w_wr_accept;
    end
  end

  assign o_mem_addr  = (r_state == ST_LOAD) ? i_dl_addr : i_cpu_addr;
  assign o_mem_we    = w_wr_accept;
  assign o_mem_wdata = i_dl_data;
  assign o_cpu_data  = i_mem_rdata;
  assign o_cpu_valid = r_cpu_valid;
  assign o_cpu_rst   = (r_state != ST_RUN);
  assign o_dl_ack    = r_dl_ack;

`ifdef ROM_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= 8'h00;
    end else if (w_load_entry) begin
      r_checksum <= 8'h00;
    end else if (w_wr_accept) begin
      r_checksum <= r_checksum + i_dl_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  logic w_unused_entry;
  assign w_unused_entry = w_load_entry;
  assign o_checksum     = 8'h00;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;

  localparam int AW = 11;
  localparam int RC = 16;
`ifdef ROM_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          cpu_valid;
  logic          cpu_rst;
  logic          dl_busy;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    checksum;

  always #5 clk = ~clk;

  rom_arbiter #(.AW(AW), .RELEASE_CYC(RC)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .o_cpu_data(cpu_data), .o_cpu_valid(cpu_valid), .o_cpu_rst(cpu_rst),
    .i_dl_busy(dl_busy), .i_dl_wr(dl_wr), .i_dl_addr(dl_addr), .i_dl_data(dl_data),
    .o_dl_ack(dl_ack),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_checksum(checksum)
  );

  logic [7:0] bram[2048];
  logic [7:0] exp_rom[2048];

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  typedef struct {
    logic          busy;
    logic          wr;
    logic [AW-1:0] daddr;
    logic [7:0]    ddata;
    logic          req;
    logic [AW-1:0] caddr;
    logic          exp_we;
    logic          exp_rst;
    logic          chk_ma;
    logic [AW-1:0] exp_ma;
    logic          chk_ck;
    logic [7:0]    exp_ck;
  } vec_t;

  vec_t tbl[15];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_q[$];
  logic       pend_valid = 1'b0;
  logic [7:0] pend_data  = 8'h00;
  logic       pend_ack   = 1'b0;
  logic       exp_ack    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sample();
    logic [7:0] e;
    @(negedge clk);
    if (cpu_valid) begin
      if (sb_q.size() == 0) begin
        chk("cpu_valid_unexpected", 32'(cpu_valid), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("cpu_data", 32'(cpu_data), 32'(e));
      end
    end else if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      chk("cpu_valid_missing", 32'(cpu_valid), 32'(1));
    end
    chk("dl_ack", 32'(dl_ack), 32'(exp_ack));
  endtask

  task automatic advance();
    @(posedge clk);
    if (pend_valid) sb_q.push_back(pend_data);
    exp_ack    = pend_ack;
    pend_valid = 1'b0;
    pend_ack   = 1'b0;
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_req    = 1'b1;
    cpu_addr   = a;
    pend_valid = 1'b1;
    pend_data  = exp_rom[a];
    step();
    cpu_req = 1'b0;
  endtask

  // Counts held cycles from the current one; returns just after the first RUN cycle's edge.
  task automatic wait_run(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!cpu_rst) break;
      if (cpu_valid) chk("cpu_valid_in_hold", 32'(cpu_valid), 32'(0));
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    if (cpu_req) sb_q.push_back(exp_rom[cpu_addr]);
    exp_ack = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    dl_busy  = 1'b1;
    dl_wr    = 1'b1;
    dl_addr  = 11'h200;
    dl_data  = 8'h99;
    for (int i = 0; i < 2048; i++) begin
      bram[i]    = 8'(i) ^ 8'hC3;
      exp_rom[i] = 8'(i) ^ 8'hC3;
    end
    bram[0]    = 8'h15;
    exp_rom[0] = 8'h15;

    //            busy  wr    daddr    ddata  req   caddr    we    rst   chkma mem_addr chkck cksum
    tbl[0]  = '{1'b0, 1'b1, 11'h03C, 8'hEE, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 11'h03C, 8'h00, 1'b1, 11'h03C, 1'b0, 1'b0, 1'b1, 11'h03C, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 11'h03C, 8'hA5, 1'b1, 11'h000, 1'b1, 1'b1, 1'b1, 11'h03C, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 11'h7FF, 8'h5A, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h7FF, 1'b1, 8'hA5};
    tbl[4]  = '{1'b0, 1'b0, 11'h7FF, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h7FF, 1'b1, 8'hFF};
    tbl[5]  = '{1'b0, 1'b1, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[6]  = '{1'b0, 1'b1, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[7]  = '{1'b0, 1'b1, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[8]  = '{1'b0, 1'b1, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[9]  = '{1'b0, 1'b1, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[10] = '{1'b1, 1'b0, 11'h03C, 8'h00, 1'b0, 11'h005, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'hFF};
    tbl[11] = '{1'b1, 1'b1, 11'h100, 8'hF0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h100, 1'b1, 8'h00};
    tbl[12] = '{1'b1, 1'b1, 11'h101, 8'h20, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h101, 1'b1, 8'hF0};
    tbl[13] = '{1'b0, 1'b1, 11'h102, 8'h01, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h102, 1'b1, 8'h10};
    tbl[14] = '{1'b0, 1'b0, 11'h102, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 8'h11};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'(1));
    chk("rst_cpu_valid", 32'(cpu_valid), 32'(0));
    chk("rst_dl_ack", 32'(dl_ack), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_checksum", 32'(checksum), 32'(0));
    @(posedge clk);
    #1;

    reset    = 1'b0;
    dl_busy  = 1'b0;
    dl_wr    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 11'h000;
    wait_run(n);
    chk("reset_release_cycles", 32'(n), 32'(RC));
    cpu_req = 1'b0;
    step();

    cpu_read(11'h7FF);
    cpu_read(11'h200);
    cpu_read(11'h001);
    cpu_read(11'h03C);
    step();

    for (int i = 0; i < 15; i++) begin
      dl_busy  = tbl[i].busy;
      dl_wr    = tbl[i].wr;
      dl_addr  = tbl[i].daddr;
      dl_data  = tbl[i].ddata;
      cpu_req  = tbl[i].req;
      cpu_addr = tbl[i].caddr;
      if (tbl[i].exp_we) begin
        pend_ack = 1'b1;
        exp_rom[tbl[i].daddr] = tbl[i].ddata;
      end
      sample();
      chk($sformatf("row%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].exp_rst));
      chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].exp_we));
      if (tbl[i].chk_ma) chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].exp_ma));
      if (tbl[i].exp_we) chk($sformatf("row%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].ddata));
      if (tbl[i].chk_ck)
        chk($sformatf("row%0d_checksum", i), 32'(checksum), CK_EN ? 32'(tbl[i].exp_ck) : 32'(0));
      advance();
    end

    dl_wr   = 1'b0;
    dl_busy = 1'b0;
    cpu_req = 1'b0;
    wait_run(n);
    chk("hold_remaining_cycles", 32'(n), 32'(RC - 1));
    cpu_read(11'h03C);
    cpu_read(11'h7FF);
    cpu_read(11'h100);
    cpu_read(11'h101);
    cpu_read(11'h102);
    step();
    chk("checksum_after_session", 32'(checksum), CK_EN ? 32'(8'h11) : 32'(0));

    dl_busy = 1'b1;
    step();
    dl_wr   = 1'b1;
    dl_addr = 11'h200;
    dl_data = 8'h99;
    reset   = 1'b1;
    sample();
    chk("reset_load_mem_we", 32'(mem_we), 32'(0));
    chk("reset_load_cpu_rst", 32'(cpu_rst), 32'(1));
    advance();
    reset   = 1'b0;
    dl_wr   = 1'b0;
    dl_busy = 1'b0;
    sample();
    chk("reset_load_checksum", 32'(checksum), 32'(0));
    chk("reset_load_hold", 32'(cpu_rst), 32'(1));
    advance();
    wait_run(n);
    chk("reset_load_release", 32'(n), 32'(RC - 1));
    cpu_read(11'h200);
    cpu_read(11'h03C);
    step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 11, program ROM address width (2048 bytes).
REQ-002 Parameter RELEASE_CYC, default 16, cycles the CPU stays in reset after a download ends; legal range 1..255.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU fetch request, sampled every cycle.
REQ-006 cpu_addr  input  AW  CPU fetch address ({pcf,pcc}).
REQ-007 cpu_data  output  8  fetched opcode byte.
REQ-008 cpu_valid  output  1  cpu_data valid strobe.
REQ-009 cpu_rst  output  1  hold-in-reset to the MCU core.
REQ-010 dl_busy  input  1  host download session active.
REQ-011 dl_wr  input  1  host byte write strobe.
REQ-012 dl_addr  input  AW  host write address.
REQ-013 dl_data  input  8  host write byte.
REQ-014 dl_ack  output  1  host write accepted, one-cycle pulse.
REQ-015 mem_addr  output  AW  single-port ROM BRAM address.
REQ-016 mem_we  output  1  BRAM write enable.
REQ-017 mem_wdata  output  8  BRAM write data.
REQ-018 mem_rdata  input  8  BRAM read data, 1-cycle synchronous latency.
REQ-019 checksum  output  8  download image checksum.

Function
REQ-020 The block SHALL be a 3-state FSM: RUN (CPU owns the ROM), LOAD (host owns the ROM), HOLD (post-load release countdown).
REQ-021 In RUN, mem_addr SHALL equal cpu_addr combinationally and mem_we SHALL be 0.
REQ-022 In RUN, a cpu_req in cycle N SHALL produce cpu_valid=1 with cpu_data=mem_rdata in cycle N+1; cpu_valid SHALL be 0 otherwise.
REQ-023 RUN->LOAD SHALL occur on the cycle after dl_busy is sampled 1; a CPU read issued in that same cycle SHALL NOT produce cpu_valid.
REQ-024 In LOAD, cpu_rst=1, cpu_valid=0, mem_addr=dl_addr, mem_wdata=dl_data, mem_we=dl_wr.
REQ-025 An accepted write (dl_wr=1 in LOAD) in cycle N SHALL pulse dl_ack in cycle N+1; back-to-back writes every cycle SHALL all be accepted.
REQ-026 dl_wr outside LOAD SHALL be ignored: no mem_we, no dl_ack.
REQ-027 LOAD->HOLD SHALL occur when dl_busy is sampled 0; a dl_wr sampled in that same cycle SHALL still be accepted.
REQ-028 On HOLD entry, an 8-bit counter SHALL load RELEASE_CYC-1 and decrement each cycle; HOLD->RUN SHALL occur when it reads 0, giving exactly RELEASE_CYC HOLD cycles.
REQ-029 In HOLD, cpu_rst=1, mem_we=0, cpu_valid=0; dl_busy=1 in HOLD SHALL return to LOAD the next cycle and abandon the countdown.
REQ-030 cpu_rst SHALL be 0 only in RUN; it SHALL deassert in the first RUN cycle.
REQ-031 Address wrap: dl_addr and cpu_addr SHALL use all AW bits, with no range check.

Reset
REQ-032 reset=1 SHALL force state HOLD with counter=RELEASE_CYC-1, cpu_rst=1, cpu_valid=0, dl_ack=0, mem_we=0, checksum=0.
REQ-033 reset asserted mid-LOAD SHALL abandon the session; a write sampled with reset=1 SHALL NOT be acked or written.
REQ-034 After reset deasserts, the CPU SHALL leave reset after RELEASE_CYC cycles, so the MCU pc=0 start is deterministic.

Configuration
REQ-035 Macro ROM_CHECKSUM_EN defined: an 8-bit checksum register SHALL clear on RUN/HOLD->LOAD entry and add dl_data mod 256 on each accepted write; it SHALL hold its value outside LOAD.
REQ-036 ROM_CHECKSUM_EN undefined: the checksum port SHALL remain and be tied to 8'h00, and no checksum logic SHALL be built.

Verification
REQ-037 After reset, cpu_req=1, cpu_addr=11'h000, ROM[0]=8'h15 -> cpu_rst drops after 16 cycles; cpu_valid=1 with cpu_data=8'h15 the cycle after the request.
REQ-038 Raise dl_busy, write 8'hA5 to 11'h3C and 8'h5A to 11'h7FF on back-to-back cycles -> two dl_ack pulses, cpu_rst=1 throughout; a later CPU read of 11'h3C returns 8'hA5.
REQ-039 cpu_req in the same cycle dl_busy rises -> no cpu_valid; next state LOAD.
REQ-040 Drop dl_busy, then re-raise it 5 cycles into HOLD -> returns to LOAD, and cpu_rst never drops.
REQ-041 dl_wr=1 while in RUN with dl_busy=0 -> mem_we=0, dl_ack=0, ROM unchanged.
REQ-042 ROM_CHECKSUM_EN defined: writes 8'hF0, 8'h20, 8'h01 -> checksum=8'h11 after the session; a new session clears it. Macro undefined: checksum=8'h00 always.
